ddr_frame_reader: RTL and testbench

Read-side client of the DDR controller's request/acknowledge port. It walks the framebuffer linearly from `BASE_ADDR`, issuing one 32-bit read per request, and buffers the returned words in a small FIFO. On the pixel side it presents them as a stream of 16-bit pixels for the VGA output stage. It sits between the DDR controller and the pixel pipeline in the same clock domain as the controller.

---
 rtl/ddr_frame_reader.sv | 136 +++++++++++++
 tb/tb_ddr_frame_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: walks a framebuffer in DDR one 32-bit word per request,
// buffers returned words in a small FIFO and streams them out as 16-bit pixels.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no request outstanding; issue one when FIFO space and frame remain
// ST_REQ     | read held high with a stable address, waiting for the ack
// ST_RELEASE | read dropped, waiting for the controller to lower its ack
module ddr_frame_reader #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int unsigned FRAME_WORDS = 153600,
  parameter int unsigned DEPTH       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frameStart,
  output logic        read,
  output logic [23:0] readAddress,
  input  logic        readAcknowledge,
  input  logic [31:0] readData,
  input  logic        pixelRead,
  output logic [15:0] pixel,
  output logic        pixelValid,
  output logic        underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RELEASE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] word_index;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      head;
  logic             half_sel;
  logic             discard;
  logic             in_flight;
  logic             can_issue;
  logic             ack_take;
  logic             push;
  logic             pop;
  logic             pix_take;

  // A request reserves one FIFO slot, so a returning word always has room.
  assign in_flight = (state == ST_REQ) && !discard;
  assign can_issue = (word_index < IDX_W'(FRAME_WORDS)) &&
                     (({1'b0, count} + {{CNT_W{1'b0}}, in_flight}) < (CNT_W + 1)'(DEPTH));

  // Next-state decode and per-cycle handshake/FIFO strobes.
  always_comb begin
    state_nxt = state;
    ack_take  = 1'b0;
    push      = 1'b0;
    pix_take  = 1'b0;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE:    if (!frameStart && can_issue) state_nxt = ST_REQ;
      ST_REQ:     if (readAcknowledge) state_nxt = ST_RELEASE;
      ST_RELEASE: if (!readAcknowledge) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    ack_take = (state == ST_REQ) && readAcknowledge;
    push     = ack_take && !discard && !frameStart;
    pix_take = pixelRead && pixelValid;
    pop      = pix_take && half_sel;
  end

  // State register plus registered read request and address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      read        <= 1'b0;
      readAddress <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_REQ) begin
        read        <= 1'b1;
        readAddress <= BASE_ADDR + 24'(word_index);
      end else if (ack_take) begin
        read <= 1'b0;
      end
    end
  end

  // Frame position; a restart mid-request marks the in-flight word as stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_index <= '0;
      discard    <= 1'b0;
    end else if (frameStart) begin
      word_index <= '0;
      discard    <= (state == ST_REQ) && !readAcknowledge;
    end else if (ack_take) begin
      if (discard) discard <= 1'b0;
      else         word_index <= word_index + IDX_W'(1);
    end
  end

  // FIFO pointers, occupancy and pixel half select.
  always_ff @(posedge clk) begin
    if (!rst_n || frameStart) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      half_sel <= 1'b0;
    end else begin
      if (push)     wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr   <= rd_ptr + PTR_W'(1);
      if (pix_take) half_sel <= ~half_sel;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= readData;
  end

  // Sticky underflow, cleared only by a frame restart or reset.
  always_ff @(posedge clk) begin
    if (!rst_n || frameStart)           underflow <= 1'b0;
    else if (pixelRead && !pixelValid)  underflow <= 1'b1;
  end

  assign head       = mem[rd_ptr];
  assign pixelValid = (count != '0);
  assign pixel      = pixelValid ? (half_sel ? head[31:16] : head[15:0]) : 16'h0000;

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Directed bench: instance 0 uses the full frame, instance 1 a 4-word frame at
// a non-zero base. A DDR controller model per instance acks requests and pushes
// the expected pixels into a per-instance scoreboard queue.
module tb_ddr_frame_reader;

  localparam logic [23:0] BASE1 = 24'h000100;

  logic        clk;
  logic        rst_n;
  logic        fs_in [2];
  logic        rd    [2];
  logic [23:0] addr  [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        prd   [2];
  logic [15:0] pix   [2];
  logic        pv    [2];
  logic        uf    [2];

  logic [15:0] sb [2][$];
  int          dly [2];
  int          hold [2];
  int          idx [2];
  int          req [2];
  int          gen [2];
  int          gap [2];
  int          fall [2];
  bit          disc [2];
  bit          frc_en [2];
  logic [31:0] frc_word [2];
  logic [23:0] base [2];
  int          cyc;
  int          n_cmp;
  int          n_err;

  ddr_frame_reader u_dut0 (
    .clk(clk), .rst_n(rst_n), .frameStart(fs_in[0]), .read(rd[0]),
    .readAddress(addr[0]), .readAcknowledge(ack[0]), .readData(rdata[0]),
    .pixelRead(prd[0]), .pixel(pix[0]), .pixelValid(pv[0]), .underflow(uf[0]));

  ddr_frame_reader #(.BASE_ADDR(BASE1), .FRAME_WORDS(4), .DEPTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .frameStart(fs_in[1]), .read(rd[1]),
    .readAddress(addr[1]), .readAcknowledge(ack[1]), .readData(rdata[1]),
    .pixelRead(prd[1]), .pixel(pix[1]), .pixelValid(pv[1]), .underflow(uf[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // DDR controller model: ack after dly cycles, hold ack for hold cycles after read drops.
  initial begin : ctrl
    bit          prev_rd [2];
    int          dcnt [2];
    int          hcnt [2];
    logic [23:0] hold_addr [2];
    logic [31:0] word;
    prev_rd = '{0, 0};
    dcnt = '{0, 0};
    hcnt = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          ack[k] = 1'b0; dcnt[k] = 0; idx[k] = 0; disc[k] = 0; prev_rd[k] = 0;
          sb[k].delete();
        end else begin
          if (rd[k] && !prev_rd[k]) begin
            req[k]++;
            chk($sformatf("addr%0d", k), 32'(addr[k]), 32'(base[k] + 24'(idx[k])));
            chk($sformatf("ack_low_at_req%0d", k), 32'(ack[k]), 0);
            gap[k] = cyc - fall[k];
            hold_addr[k] = addr[k];
          end else if (rd[k]) begin
            chk($sformatf("addr_stable%0d", k), 32'(addr[k]), 32'(hold_addr[k]));
          end
          prev_rd[k] = rd[k];
          if (ack[k]) begin
            if (!rd[k]) begin
              if (hcnt[k] >= hold[k]) begin ack[k] = 1'b0; fall[k] = cyc; end
              else hcnt[k]++;
            end
          end else if (rd[k]) begin
            dcnt[k]++;
            if (dcnt[k] >= dly[k]) begin
              word = frc_en[k] ? frc_word[k] : {16'(2 * gen[k] + 2), 16'(2 * gen[k] + 1)};
              frc_en[k] = 0;
              gen[k]++;
              rdata[k] = word;
              ack[k] = 1'b1;
              dcnt[k] = 0;
              hcnt[k] = 0;
              if (disc[k]) disc[k] = 0;
              else begin
                sb[k].push_back(word[15:0]);
                sb[k].push_back(word[31:16]);
                idx[k]++;
              end
            end
          end
        end
      end
    end
  end

  // Called at posedge+2; pulses frameStart across one edge and mirrors its effect.
  task automatic frame_start(input int k);
    fs_in[k] = 1'b1;
    if (rd[k] && !ack[k]) disc[k] = 1;
    sb[k].delete();
    idx[k] = 0;
    req[k] = 0;
    @(posedge clk);
    #2;
    fs_in[k] = 1'b0;
  endtask

  task automatic pop(input int k, output logic [15:0] got);
    int t = 0;
    while (!pv[k] && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk($sformatf("pv_wait%0d", k), 32'(pv[k]), 1);
    got = pix[k];
    if (sb[k].size() != 0) chk($sformatf("pixel%0d", k), 32'(pix[k]), 32'(sb[k].pop_front()));
    else chk($sformatf("sb_has_data%0d", k), 32'(sb[k].size()), 1);
    prd[k] = 1'b1;
    @(posedge clk);
    #2;
    prd[k] = 1'b0;
  endtask

  task automatic wait_req(input int k, input int target, input int budget);
    int t = 0;
    while (req[k] < target && t < budget) begin
      @(posedge clk);
      #2;
      t++;
    end
  endtask

  initial begin
    logic [15:0] got;
    int t;
    int r0;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    fs_in = '{0, 0}; prd = '{0, 0}; ack = '{0, 0}; rdata = '{0, 0};
    dly = '{3, 2}; hold = '{0, 0}; req = '{0, 0}; gen = '{0, 0};
    gap = '{0, 0}; fall = '{0, 0}; frc_en = '{0, 0}; frc_word = '{0, 0};
    base = '{24'h000000, BASE1};
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_read%0d", k), 32'(rd[k]), 0);
      chk($sformatf("rst_addr%0d", k), 32'(addr[k]), 0);
      chk($sformatf("rst_pixel%0d", k), 32'(pix[k]), 0);
      chk($sformatf("rst_pv%0d", k), 32'(pv[k]), 0);
      chk($sformatf("rst_uf%0d", k), 32'(uf[k]), 0);
    end
    rst_n = 1'b1;

    // Linear read with slow acks: pixels 1,2,3,... in order.
    for (int i = 0; i < 8; i++) begin
      pop(0, got);
      chk("t1_seq", 32'(got), 32'(i + 1));
    end

    // Immediate acks, no consumer: exactly DEPTH requests, then one per popped pair.
    dly[0] = 1;
    frame_start(0);
    repeat (120) @(posedge clk);
    #2;
    chk("t2_req16", req[0], 16);
    chk("t2_read_idle", 32'(rd[0]), 0);
    chk("t2_pv", 32'(pv[0]), 1);
    pop(0, got);
    pop(0, got);
    repeat (40) @(posedge clk);
    #2;
    chk("t2_req17", req[0], 17);
    chk("t2_read_idle2", 32'(rd[0]), 0);

    // Ack held 5 cycles past read falling: next read exactly 2 cycles after ack drops.
    hold[0] = 5;
    frame_start(0);
    wait_req(0, 1, 100);
    for (int i = 0; i < 3; i++) begin
      r0 = req[0];
      wait_req(0, r0 + 1, 100);
      chk("t3_gap", gap[0], 2);
    end

    // Restart while waiting on the word at address 7: word dropped, frame restarts at base.
    hold[0] = 0;
    dly[0] = 6;
    frame_start(0);
    t = 0;
    while (!(rd[0] && addr[0] == 24'd7 && !ack[0]) && t < 400) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("t4_at_addr7", 32'(addr[0]), 7);
    frc_word[0] = 32'hDEAD_BEEF;
    frc_en[0] = 1;
    frame_start(0);
    wait_req(0, 1, 100);
    chk("t4_restart_addr", 32'(addr[0]), 0);
    chk("t4_pv_empty", 32'(pv[0]), 0);

    // Short frame: 4 requests then idle, underflow after 8 pixels, cleared by restart.
    chk("t5_req4", req[1], 4);
    chk("t5_read_idle", 32'(rd[1]), 0);
    for (int i = 0; i < 8; i++) begin
      pop(1, got);
      chk("t5_seq", 32'(got), 32'(i + 1));
    end
    chk("t5_pv_empty", 32'(pv[1]), 0);
    chk("t5_uf_before", 32'(uf[1]), 0);
    prd[1] = 1'b1;
    @(posedge clk);
    #2;
    prd[1] = 1'b0;
    chk("t5_uf_set", 32'(uf[1]), 1);
    chk("t5_pixel_zero", 32'(pix[1]), 0);
    chk("t5_read_still_idle", 32'(rd[1]), 0);
    frame_start(1);
    chk("t5_uf_clear", 32'(uf[1]), 0);
    repeat (60) @(posedge clk);
    #2;
    chk("t5_req_refill", req[1], 4);

    // Reset while in REQ: read drops and all outputs return to reset values.
    dly[0] = 10;
    t = 0;
    while (!(rd[0] && !ack[0]) && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("t6_in_req", 32'(rd[0]), 1);
    chk("t6_pv_before", 32'(pv[0]), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("t6_read", 32'(rd[0]), 0);
    chk("t6_addr", 32'(addr[0]), 0);
    chk("t6_pixel", 32'(pix[0]), 0);
    chk("t6_pv", 32'(pv[0]), 0);
    chk("t6_uf", 32'(uf[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
